// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and elaboration helpers for the push-button debouncer
//
// Contents:
//   pb_state_t - per-channel filter state (REL, P_CHK, PRS, R_CHK)
//   calc_div   - clock cycles per sample tick
//   cnt_width  - bits needed to hold a counter value 0..max_val
package pb_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,  // released, stable
    P_CHK = 2'd1,  // released, qualifying a press
    PRS   = 2'd2,  // pressed, stable
    R_CHK = 2'd3   // pressed, qualifying a release
  } pb_state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_db_channel.sv
// rtl/pb_db_channel.sv - one debounce channel: synchroniser, stable-count FSM, event pulses
//
// Ports:
//   clk_in    in   system clock
//   rst_n     in   asynchronous active-low reset
//   tick      in   sample strobe shared by all channels
//   pb        in   raw asynchronous button input
//   level     out  debounced pressed state (1 = pressed)
//   press_p   out  one-cycle pulse on an accepted press
//   release_p out  one-cycle pulse on an accepted release
//   long_p    out  one-cycle pulse once per press after HOLD_TICKS pressed ticks
module pb_db_channel #(
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 1000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick,
  input  logic pb,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p
);
  import pb_pkg::*;

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam int HW = cnt_width(HOLD_TICKS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic          sync1, sync2, s;
  pb_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic          press_nxt, release_nxt, long_nxt;

  // Synchroniser idles at the released raw level so reset never looks like a press.
  assign s        = sync2 ^ ACTIVE_LOW;
  assign cnt_inc  = cnt + CW'(1);
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
  assign level    = (state == PRS) || (state == R_CHK);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= ACTIVE_LOW;
      sync2     <= ACTIVE_LOW;
      state     <= REL;
      cnt       <= '0;
      hold_cnt  <= '0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
    end else begin
      sync1     <= pb;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_nxt;
      press_p   <= press_nxt;
      release_p <= release_nxt;
      long_p    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold_cnt;
    if (tick) begin
      case (state)
        REL: begin
          if (s) begin
            if (CNT_MAX == CW'(1)) begin
              state_nxt = PRS;
              cnt_nxt   = '0;
              hold_nxt  = '0;
            end else begin
              state_nxt = P_CHK;
              cnt_nxt   = CW'(1);
            end
          end
        end
        P_CHK: begin
          if (!s) begin
            // A bounce restarts qualification from scratch.
            state_nxt = REL;
            cnt_nxt   = '0;
            hold_nxt  = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_nxt = PRS;
            cnt_nxt   = '0;
            hold_nxt  = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        PRS: begin
          if (!s) begin
            if (CNT_MAX == CW'(1)) begin
              state_nxt = REL;
              cnt_nxt   = '0;
              hold_nxt  = '0;
            end else begin
              state_nxt = R_CHK;
              cnt_nxt   = CW'(1);
            end
          end else begin
            hold_nxt = hold_inc;
          end
        end
        R_CHK: begin
          if (s) begin
            // Release bounce: still the same press, so hold time keeps accruing.
            state_nxt = PRS;
            cnt_nxt   = '0;
            hold_nxt  = hold_inc;
          end else if (cnt_inc == CNT_MAX) begin
            state_nxt = REL;
            cnt_nxt   = '0;
            hold_nxt  = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = REL;
          cnt_nxt   = '0;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_nxt   = ((state == REL) || (state == P_CHK)) && (state_nxt == PRS);
    release_nxt = ((state == PRS) || (state == R_CHK)) && (state_nxt == REL);
    // hold_cnt saturates and only clears on a new press, so this edge occurs once per press.
    long_nxt    = (hold_nxt == HOLD_MAX) && (hold_cnt != HOLD_MAX);
  end

endmodule

// File: rtl/pb_debounce_multi.sv
// rtl/pb_debounce_multi.sv - N-channel push-button debouncer with shared sample-tick prescaler
//
// Ports:
//   clk_in    in   system clock, single domain
//   rst_n     in   asynchronous active-low reset
//   pb        in   [N_CH] raw asynchronous button inputs
//   level     out  [N_CH] debounced pressed state (1 = pressed)
//   press_p   out  [N_CH] one-cycle pulse on an accepted press
//   release_p out  [N_CH] one-cycle pulse on an accepted release
//   long_p    out  [N_CH] one-cycle pulse once per press after HOLD_TICKS
//   tick      out  prescaler strobe, one cycle every CLK_HZ/TICK_HZ cycles
module pb_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 1000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic            tick
);
  import pb_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("pb_debounce_multi: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (STABLE_TICKS < 1 || HOLD_TICKS < 1) begin : g_cnt_check
    $error("pb_debounce_multi: STABLE_TICKS and HOLD_TICKS must be at least 1");
  end

  logic [PW-1:0] div_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_db_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .tick      (tick),
      .pb        (pb[i]),
      .level     (level[i]),
      .press_p   (press_p[i]),
      .release_p (release_p[i]),
      .long_p    (long_p[i])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb/tb_pb_debounce_multi.sv - self-checking bench for pb_debounce_multi (active-high and active-low instances)
module tb_pb_debounce_multi;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int S   = 4;
  localparam int H   = 10;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic [N-1:0] pb_a, pb_b;
  logic [N-1:0] level_a, press_a, rel_a, long_a;
  logic [N-1:0] level_b, press_b, rel_b, long_b;
  logic         tick_a, tick_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  pb_debounce_multi #(
    .N_CH(N), .CLK_HZ(4000), .TICK_HZ(1000), .STABLE_TICKS(S), .HOLD_TICKS(H), .ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk_in(clk_in), .rst_n(rst_n), .pb(pb_a), .level(level_a), .press_p(press_a),
    .release_p(rel_a), .long_p(long_a), .tick(tick_a)
  );

  pb_debounce_multi #(
    .N_CH(N), .CLK_HZ(4000), .TICK_HZ(1000), .STABLE_TICKS(S), .HOLD_TICKS(H), .ACTIVE_LOW(1'b1)
  ) u_dut_lo (
    .clk_in(clk_in), .rst_n(rst_n), .pb(pb_b), .level(level_b), .press_p(press_b),
    .release_p(rel_b), .long_p(long_b), .tick(tick_b)
  );

  // Reference model, in pressed polarity: a level flips after S consecutive
  // sampled ticks disagreeing with it; hold time counts pressed ticks since the press.
  logic [N-1:0] m_h1[2], m_h2[2];
  logic [N-1:0] m_level[2], m_press[2], m_rel[2], m_long[2];
  int           m_run[2][N];
  int           m_hold[2][N];
  int           cyc;
  logic         m_tick;

  int   n_press[N], n_rel[N], n_long[N], n_lvl[N];
  logic seen_1001;

  task automatic model_reset();
    cyc    = 0;
    m_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_h1[i] = '0; m_h2[i] = '0; m_level[i] = '0;
      m_press[i] = '0; m_rel[i] = '0; m_long[i] = '0;
      for (int c = 0; c < N; c++) begin
        m_run[i][c]  = 0;
        m_hold[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] now;
    logic         ev;
    logic         s;
    if (!rst_n) return;
    cyc++;
    ev     = (cyc > 1) && ((cyc - 1) % DIV == 0);
    m_tick = (cyc % DIV == 0);
    for (int i = 0; i < 2; i++) begin
      now = (i == 0) ? pb_a : ~pb_b;
      m_press[i] = '0; m_rel[i] = '0; m_long[i] = '0;
      if (ev) begin
        for (int c = 0; c < N; c++) begin
          s = m_h2[i][c];
          if (m_level[i][c]) begin
            if (s) begin
              m_run[i][c] = 0;
              if (m_hold[i][c] < H) begin
                m_hold[i][c]++;
                if (m_hold[i][c] == H) m_long[i][c] = 1'b1;
              end
            end else begin
              m_run[i][c]++;
              if (m_run[i][c] == S) begin
                m_level[i][c] = 1'b0; m_rel[i][c] = 1'b1; m_run[i][c] = 0;
              end
            end
          end else begin
            if (s) begin
              m_run[i][c]++;
              if (m_run[i][c] == S) begin
                m_level[i][c] = 1'b1; m_press[i][c] = 1'b1;
                m_run[i][c] = 0; m_hold[i][c] = 0;
              end
            end else begin
              m_run[i][c] = 0;
            end
          end
        end
      end
      m_h2[i] = m_h1[i];
      m_h1[i] = now;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level_a", level_a, m_level[0]);
    chk("press_a", press_a, m_press[0]);
    chk("release_a", rel_a, m_rel[0]);
    chk("long_a", long_a, m_long[0]);
    chk("tick_a", {3'b000, tick_a}, {3'b000, m_tick});
    chk("level_b", level_b, m_level[1]);
    chk("press_b", press_b, m_press[1]);
    chk("release_b", rel_b, m_rel[1]);
    chk("long_b", long_b, m_long[1]);
    chk("tick_b", {3'b000, tick_b}, {3'b000, m_tick});
  endtask

  task automatic clear_counts();
    seen_1001 = 1'b0;
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_lvl[c] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    check_all();
    if (press_a == 4'b1001) seen_1001 = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (press_a[c]) n_press[c]++;
      if (rel_a[c])   n_rel[c]++;
      if (long_a[c])  n_long[c]++;
      if (level_a[c]) n_lvl[c]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int ch;
    rst_n = 1'b1;
    pb_a  = '0;
    pb_b  = '1;
    clear_counts();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    run(3);
    #2 rst_n = 1'b1;

    // Idle after reset: no activity on either polarity.
    clear_counts();
    run(12);
    chk("idle_press_cnt", 4'(n_press[0] + n_press[1] + n_press[2] + n_press[3]), 4'd0);

    // Clean press on channel 0, held long enough for a long press.
    clear_counts();
    pb_a[0] = 1'b1; pb_b[0] = 1'b0;
    run(40);
    chk("clean_press_cnt", 4'(n_press[0]), 4'd1);
    chk("clean_other_lvl", 4'(n_lvl[1] + n_lvl[2] + n_lvl[3]), 4'd0);
    chk("clean_level", level_a, 4'b0001);
    run(80);
    chk("long_cnt", 4'(n_long[0]), 4'd1);

    // Release after long press.
    clear_counts();
    pb_a[0] = 1'b0; pb_b[0] = 1'b1;
    run(40);
    chk("release_cnt", 4'(n_rel[0]), 4'd1);
    chk("release_level", level_a, 4'b0000);

    // Bounce on channel 1: toggles every tick for 20 ticks, then settles low.
    clear_counts();
    for (int t = 0; t < 20; t++) begin
      pb_a[1] = ~pb_a[1]; pb_b[1] = ~pb_b[1];
      run(DIV);
    end
    run(40);
    chk("bounce_press_cnt", 4'(n_press[1]), 4'd0);
    chk("bounce_rel_cnt", 4'(n_rel[1]), 4'd0);
    chk("bounce_lvl_cnt", 4'(n_lvl[1]), 4'd0);

    // Simultaneous press on channels 0 and 3.
    clear_counts();
    pb_a = 4'b1001; pb_b = 4'b0110;
    run(40);
    chk("simul_press_1001", {3'b000, seen_1001}, 4'b0001);

    // Asynchronous reset while held.
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("async_rst_level", level_a, 4'b0000);
    run(3);
    #2 rst_n = 1'b1;
    clear_counts();
    run(40);
    chk("post_rst_rel_cnt", 4'(n_rel[0]), 4'd0);
    chk("post_rst_press_cnt", 4'(n_press[0] + n_press[3]), 4'd2);

    // Randomized traffic on both instances.
    pb_a = '0; pb_b = '1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        ch = int'($urandom_range(0, N - 1));
        pb_a[ch] = ~pb_a[ch];
      end
      if ($urandom_range(0, 15) == 0) begin
        ch = int'($urandom_range(0, N - 1));
        pb_b[ch] = ~pb_b[ch];
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
